// File: rtl/hazard5_muldiv_pkg.sv
// Shared definitions for the hazard5 sequential multiply/divide unit:
// M-extension funct3 encodings, FSM state type and operand-sign helpers.
package hazard5_muldiv_pkg;

    localparam logic [2:0] M_OP_MUL    = 3'b000;
    localparam logic [2:0] M_OP_MULH   = 3'b001;
    localparam logic [2:0] M_OP_MULHSU = 3'b010;
    localparam logic [2:0] M_OP_MULHU  = 3'b011;
    localparam logic [2:0] M_OP_DIV    = 3'b100;
    localparam logic [2:0] M_OP_DIVU   = 3'b101;
    localparam logic [2:0] M_OP_REM    = 3'b110;
    localparam logic [2:0] M_OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_a_signed(input logic [2:0] op);
        return (op == M_OP_MULH) || (op == M_OP_MULHSU) || (op == M_OP_DIV) || (op == M_OP_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == M_OP_MULH) || (op == M_OP_DIV) || (op == M_OP_REM);
    endfunction

endpackage

// File: rtl/hazard5_muldiv_seq.sv
// Sequential RV32M multiply/divide: shift-add multiply and restoring divide on
// a shared 2*XLEN accumulator, UNROLL bits per cycle, sign fix-up in one extra cycle.
module hazard5_muldiv_seq
    import hazard5_muldiv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      op,
    input  logic            op_vld,
    output logic            op_rdy,
    input  logic            op_kill,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] result,
    output logic            result_vld
);

    localparam int N  = XLEN / UNROLL;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // Handshake: an op transfers on a rising clk edge when op_vld & op_rdy are
    // both high and op_kill is low; op_rdy depends only on the FSM state.
    md_state_t         state;
    logic [2:0]        op_r;
    logic              neg_r;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] accum;
    logic [XLEN-1:0]   md_r;

    logic              accept;
    logic              a_neg, b_neg, neg_next;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [2*XLEN-1:0] step_nxt;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

    assign op_rdy = (state == MD_IDLE) || (state == MD_DONE);
    assign accept = op_vld && op_rdy && !op_kill;

    assign a_neg = op_a_signed(op) && op_a[XLEN-1];
    assign b_neg = op_b_signed(op) && op_b[XLEN-1];
    assign a_mag = a_neg ? -op_a : op_a;
    assign b_mag = b_neg ? -op_b : op_b;

    // Remainder takes the dividend's sign; a zero divisor leaves the all-ones quotient alone.
    assign neg_next = !op_is_div(op) ? (a_neg ^ b_neg) :
                      op[1]          ? a_neg :
                                       ((a_neg ^ b_neg) && (|op_b));

    function automatic logic [2*XLEN-1:0] md_step(
        input logic [2*XLEN-1:0] acc,
        input logic [XLEN-1:0]   d,
        input logic              is_div
    );
        logic [XLEN:0]   sum;
        logic [XLEN:0]   sh;
        logic [XLEN-1:0] diff;
        sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, d} : '0);
        sh   = acc[2*XLEN-1:XLEN-1];
        diff = sh[XLEN-1:0] - d;
        if (!is_div)
            return {sum, acc[XLEN-1:1]};
        else if (sh >= {1'b0, d})
            return {diff, acc[XLEN-2:0], 1'b1};
        else
            return {sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    endfunction

    always_comb begin
        step_nxt = accum;
        for (int i = 0; i < UNROLL; i++)
            step_nxt = md_step(step_nxt, md_r, op_is_div(op_r));
    end

    always_comb begin
        prod_fix = neg_r ? -accum : accum;
        quo_fix  = neg_r ? -accum[XLEN-1:0] : accum[XLEN-1:0];
        rem_fix  = neg_r ? -accum[2*XLEN-1:XLEN] : accum[2*XLEN-1:XLEN];
        fix_val  = rem_fix;
        case (op_r)
            M_OP_MUL:                            fix_val = prod_fix[XLEN-1:0];
            M_OP_MULH, M_OP_MULHSU, M_OP_MULHU:  fix_val = prod_fix[2*XLEN-1:XLEN];
            M_OP_DIV, M_OP_DIVU:                 fix_val = quo_fix;
            default:                             fix_val = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= MD_IDLE;
            op_r       <= '0;
            neg_r      <= 1'b0;
            count      <= '0;
            accum      <= '0;
            md_r       <= '0;
            result     <= '0;
            result_vld <= 1'b0;
        end else if (op_kill) begin
            state      <= MD_IDLE;
            result_vld <= 1'b0;
        end else if (accept) begin
            state      <= MD_RUN;
            op_r       <= op;
            neg_r      <= neg_next;
            count      <= CW'(N - 1);
            result_vld <= 1'b0;
            // Divide walks the dividend up from the low half; multiply shifts the multiplier out of it.
            if (op_is_div(op)) begin
                accum <= {{XLEN{1'b0}}, a_mag};
                md_r  <= b_mag;
            end else begin
                accum <= {{XLEN{1'b0}}, b_mag};
                md_r  <= a_mag;
            end
        end else begin
            case (state)
                MD_RUN: begin
                    accum <= step_nxt;
                    if (count == '0)
                        state <= MD_FIX;
                    else
                        count <= count - 1'b1;
                end
                MD_FIX: begin
                    result     <= fix_val;
                    result_vld <= 1'b1;
                    state      <= MD_DONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard5_muldiv_seq.sv
// Bench for hazard5_muldiv_seq: directed RV32M vectors, kill/reset scenarios and
// random ops against a 64-bit reference, checked by an expected-queue monitor.
module tb_hazard5_muldiv_seq;
    import hazard5_muldiv_pkg::*;

    localparam int XLEN   = 32;
    localparam int UNROLL = 1;
    localparam int LAT    = XLEN / UNROLL + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  op = '0;
    logic        op_vld = 1'b0;
    logic        op_rdy;
    logic        op_kill = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [31:0] result;
    logic        result_vld;

    hazard5_muldiv_seq #(.XLEN(XLEN), .UNROLL(UNROLL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .op_vld     (op_vld),
        .op_rdy     (op_rdy),
        .op_kill    (op_kill),
        .op_a       (op_a),
        .op_b       (op_b),
        .result     (result),
        .result_vld (result_vld)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // scoreboard state
    logic [31:0] exp_q[$];
    int          acc_q[$];
    string       name_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sub, p;
        logic [63:0]        up;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        sub = {32'b0, b};
        up  = {32'b0, a} * {32'b0, b};
        case (o)
            M_OP_MUL:    begin p = sa * sb;  return p[31:0];  end
            M_OP_MULH:   begin p = sa * sb;  return p[63:32]; end
            M_OP_MULHSU: begin p = sa * sub; return p[63:32]; end
            M_OP_MULHU:  return up[63:32];
            M_OP_DIV:    begin
                if (b == 0) return 32'hFFFFFFFF;
                p = sa / sb; return p[31:0];
            end
            M_OP_DIVU:   return (b == 0) ? 32'hFFFFFFFF : a / b;
            M_OP_REM:    begin
                if (b == 0) return a;
                p = sa % sb; return p[31:0];
            end
            default:     return (b == 0) ? a : a % b;
        endcase
    endfunction

    // monitor: one comparison per rising edge of result_vld
    logic prev_vld = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vld = 1'b0;
        end else begin
            if (result_vld && !prev_vld) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_result: got 0x%08h, expected no result", result);
                end else begin
                    string       nm;
                    logic [31:0] e;
                    int          a;
                    nm = name_q.pop_front();
                    e  = exp_q.pop_front();
                    a  = acc_q.pop_front();
                    check(nm, result, e);
                    check({nm, "_latency"}, 32'(cyc - a), 32'(LAT));
                end
            end
            prev_vld = result_vld;
        end
    end

    // driver: call at a negedge; waits for op_rdy, holds op_vld for one edge
    task automatic drive(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e, input bit track);
        int guard = 0;
        while (!op_rdy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_rdy_timeout: got op_rdy=0, expected 1 within 200 cycles", name);
        end
        op = o; op_a = a; op_b = b; op_vld = 1'b1;
        if (track) begin
            name_q.push_back(name);
            exp_q.push_back(e);
            acc_q.push_back(cyc);
        end
        @(negedge clk);
        op_vld = 1'b0;
        op     = 3'($urandom_range(0, 7));
        op_a   = $urandom;
        op_b   = $urandom;
    endtask

    task automatic issue(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e);
        drive(name, o, a, b, e, 1'b1);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
            exp_q.delete(); acc_q.delete(); name_q.delete();
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h80000000;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h00000000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        n_err++;
        $display("FAIL watchdog: got no completion, expected finish within 20000 cycles");
        summary();
        $finish;
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_op_rdy", {31'b0, op_rdy}, 32'd1);
        check("reset_result_vld", {31'b0, result_vld}, 32'd0);
        check("reset_result", result, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // directed, issued back-to-back in each DONE cycle
        issue("mul_7_m3",       M_OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB);
        issue("mulh_min_min",   M_OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000);
        issue("mulhu_ones",     M_OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        issue("mulhsu_ones",    M_OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        issue("div_m7_2",       M_OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD);
        issue("rem_m7_2",       M_OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF);
        issue("divu_100_7",     M_OP_DIVU,   32'd100,      32'd7,        32'd14);
        issue("remu_100_7",     M_OP_REMU,   32'd100,      32'd7,        32'd2);
        issue("div_ovf",        M_OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        issue("rem_ovf",        M_OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000);
        issue("div_m5_0",       M_OP_DIV,    32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF);
        issue("rem_m5_0",       M_OP_REM,    32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB);
        issue("remu_5_0",       M_OP_REMU,   32'd5,        32'd0,        32'd5);
        issue("divu_5_0",       M_OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF);
        issue("mul_big",        M_OP_MUL,    32'h00010001, 32'h00010001, 32'h00020001);
        drain();

        // kill at RUN cycle 10
        drive("kill_op", M_OP_DIVU, 32'd100, 32'd7, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        op_kill = 1'b1;
        @(negedge clk);
        op_kill = 1'b0;
        check("kill_op_rdy", {31'b0, op_rdy}, 32'd1);
        check("kill_result_vld", {31'b0, result_vld}, 32'd0);
        repeat (40) @(negedge clk);
        check("kill_no_result", {31'b0, result_vld}, 32'd0);
        issue("after_kill", M_OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        drain();

        // kill and op_vld together: no accept
        op = M_OP_MUL; op_a = 32'd3; op_b = 32'd3; op_vld = 1'b1; op_kill = 1'b1;
        @(negedge clk);
        op_vld = 1'b0; op_kill = 1'b0;
        check("kill_vld_op_rdy", {31'b0, op_rdy}, 32'd1);
        repeat (40) @(negedge clk);
        check("kill_vld_no_result", {31'b0, result_vld}, 32'd0);

        // async reset mid-RUN
        drive("reset_op", M_OP_DIV, 32'hFFFFFFF9, 32'd2, 32'd0, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_op_rdy", {31'b0, op_rdy}, 32'd1);
        check("midrst_result_vld", {31'b0, result_vld}, 32'd0);
        check("midrst_result", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue("after_reset", M_OP_REMU, 32'd100, 32'd7, 32'd2);
        drain();

        // random ops against the 64-bit reference
        for (int i = 0; i < 24; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = pick_operand();
            rb = pick_operand();
            issue($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, ref_md(ro, ra, rb));
        end
        drain();

        repeat (3) @(negedge clk);
        summary();
        $finish;
    end

endmodule
